// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream demultiplexer family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package stream_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 4;

  // Ceiling log2; callers guarantee n >= 2 so the result is never zero.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Bit offset of channel ch inside a flat CHANNELS*width bus.
  function automatic int chan_offset(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/stream_demux_n_if.sv
// Bundle of the source-side and sink-side stream signals of the demux.
// Latency: n/a (wiring only).
// Backpressure: in_ready toward the source, out_ready per sink channel.
interface stream_demux_n_if import stream_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = clog2(CHANNELS)
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic                      bcast;
  logic [WIDTH-1:0]          in_data;
  logic [SEL_W-1:0]          in_sel;
  logic [CHANNELS-1:0]       out_valid;
  logic [CHANNELS-1:0]       out_ready;
  logic [CHANNELS*WIDTH-1:0] out_data;

  // The demux itself: consumes the source beat, drives the sinks.
  modport slave (
    input  in_valid, bcast, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

  // The environment: drives the source beat and the sink readies.
  modport master (
    output in_valid, bcast, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry registered holding slot feeding a single sink channel.
// Latency: 1 cycle from load to valid.
// Backpressure: free whenever empty or being drained this cycle.
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             free
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load wins over pop so a simultaneous pop+load keeps valid high with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (load) begin
      r_valid <= 1'b1;
      r_data  <= din;
    end else if (r_valid && pop_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign dout  = r_data;
  assign free  = !r_valid || pop_ready;

endmodule

// File: rtl/stream_demux_n.sv
// Routes one valid/ready stream to one of CHANNELS sinks, or to all of them.
// Latency: 1 cycle from accept to out_valid; err_sel pulses 1 cycle after a drop.
// Backpressure: in_ready follows the target slot (AND of all slots in broadcast).
module stream_demux_n import stream_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int SEL_W    = clog2(CHANNELS),
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  stream_demux_n_if.slave     bus,
  output logic                err_sel,
  output logic [CNT_W-1:0]    drop_count
);

  localparam logic [SEL_W:0] CH_LIMIT = CHANNELS[SEL_W:0];

  logic                      w_sel_ok;
  logic [CHANNELS-1:0]       w_sel_hot;
  logic [CHANNELS-1:0]       w_slot_free;
  logic [CHANNELS-1:0]       w_slot_valid;
  logic [CHANNELS-1:0]       w_load;
  logic [WIDTH-1:0]          w_dout [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] w_out_data;
  logic                      w_in_ready;
  logic                      w_accept;
  logic                      w_drop;
  logic                      r_err_sel;
  logic [CNT_W-1:0]          r_drop_count;

  assign w_sel_ok = ({1'b0, bus.in_sel} < CH_LIMIT);

  // One-hot decode of the destination; all zero for an out-of-range select.
  always_comb begin
    w_sel_hot = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sel_hot[i] = w_sel_ok && (bus.in_sel == SEL_W'(i));
    end
  end

  // Ready toward the source: broadcast needs every slot, unicast its own, bad selects are sunk.
  always_comb begin
    w_in_ready = 1'b0;
    if (enable) begin
      if (bus.bcast)     w_in_ready = &w_slot_free;
      else if (w_sel_ok) w_in_ready = |(w_sel_hot & w_slot_free);
      else               w_in_ready = 1'b1;
    end
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_drop   = w_accept && !bus.bcast && !w_sel_ok;

  // Broadcast only accepts when all slots are free, so it always loads every slot at once.
  always_comb begin
    w_load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_load[i] = w_accept && (bus.bcast || w_sel_hot[i]);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (w_load[g]),
      .din       (bus.in_data),
      .pop_ready (bus.out_ready[g]),
      .valid     (w_slot_valid[g]),
      .dout      (w_dout[g]),
      .free      (w_slot_free[g])
    );
  end

  // Pack the per-channel slot outputs onto the flat output bus.
  always_comb begin
    w_out_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_out_data[chan_offset(i, WIDTH) +: WIDTH] = w_dout[i];
    end
  end

  // Error pulse and saturating drop counter for beats sunk on an invalid select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_sel    <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_err_sel <= w_drop;
      if (w_drop && (r_drop_count != {CNT_W{1'b1}})) begin
        r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_slot_valid;
  assign bus.out_data  = w_out_data;
  assign err_sel       = r_err_sel;
  assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 4-channel and a 3-channel instance.
// Latency: checks 1-cycle accept-to-output and 1-cycle error pulse.
// Backpressure: exercises per-channel stalls, broadcast all-or-nothing, enable gating.
module tb_stream_demux_n;

  logic clk;
  logic rst_n;
  logic enable;
  logic err4, err3;
  logic [7:0] drop4, drop3;

  int n_chk;
  int n_pass;

  stream_demux_n_if #(.WIDTH(8), .CHANNELS(4)) b4 ();
  stream_demux_n_if #(.WIDTH(8), .CHANNELS(3)) b3 ();

  stream_demux_n #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(b4.slave),
    .err_sel(err4), .drop_count(drop4)
  );

  stream_demux_n #(.WIDTH(8), .CHANNELS(3), .CNT_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(b3.slave),
    .err_sel(err3), .drop_count(drop3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    b4.in_valid = 1'b0; b4.bcast = 1'b0; b4.in_data = '0; b4.in_sel = '0; b4.out_ready = '0;
    b3.in_valid = 1'b0; b3.bcast = 1'b0; b3.in_data = '0; b3.in_sel = '0; b3.out_ready = '0;
    step();
    step();
    check("rst_out_valid", b4.out_valid, 0);
    check("rst_out_data", b4.out_data, 0);
    check("rst_err_sel", err4, 0);
    check("rst_drop_count", drop4, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    b4.out_ready = 4'hF;
    step();

    // Unicast sweep: each channel gets one beat, visible one cycle after accept.
    for (int s = 0; s < 4; s++) begin
      b4.in_valid = 1'b1;
      b4.in_sel = 2'(s);
      b4.in_data = 8'hA0 + 8'(s);
      #1;
      check("sweep_in_ready", b4.in_ready, 1);
      step();
      check("sweep_out_valid", b4.out_valid, 32'(1 << s));
      check("sweep_out_data", b4.out_data[s*8 +: 8], 32'(8'hA0 + 8'(s)));
    end
    b4.in_valid = 1'b0;
    step();
    check("sweep_drained", b4.out_valid, 0);

    // Back-pressure on channel 2, then pop and load in the same cycle.
    b4.out_ready = 4'b1011;
    b4.in_valid = 1'b1; b4.in_sel = 2'd2; b4.in_data = 8'h11;
    #1;
    check("bp_first_ready", b4.in_ready, 1);
    step();
    check("bp_held_valid", b4.out_valid, 4'b0100);
    check("bp_held_data", b4.out_data[16 +: 8], 8'h11);
    b4.in_data = 8'h22;
    #1;
    check("bp_second_stall", b4.in_ready, 0);
    step();
    check("bp_still_held", b4.out_data[16 +: 8], 8'h11);
    b4.out_ready = 4'hF;
    #1;
    check("bp_release_ready", b4.in_ready, 1);
    step();
    check("bp_no_bubble_valid", b4.out_valid, 4'b0100);
    check("bp_no_bubble_data", b4.out_data[16 +: 8], 8'h22);
    b4.in_valid = 1'b0;
    step();
    check("bp_drained", b4.out_valid, 0);

    // Broadcast: fill every slot, then broadcast blocked by channel 2 only.
    b4.out_ready = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      b4.in_valid = 1'b1; b4.in_sel = 2'(s); b4.in_data = 8'h30 + 8'(s);
      step();
    end
    b4.in_valid = 1'b0;
    check("bc_all_full", b4.out_valid, 4'hF);
    b4.out_ready = 4'b1011;
    b4.bcast = 1'b1; b4.in_data = 8'h5A; b4.in_sel = 2'd0; b4.in_valid = 1'b1;
    #1;
    check("bc_blocked_ready", b4.in_ready, 0);
    step();
    check("bc_no_partial_valid", b4.out_valid, 4'b0100);
    check("bc_no_partial_data", b4.out_data[16 +: 8], 8'h32);
    b4.out_ready = 4'hF;
    #1;
    check("bc_release_ready", b4.in_ready, 1);
    step();
    b4.in_valid = 1'b0; b4.bcast = 1'b0;
    check("bc_all_valid", b4.out_valid, 4'hF);
    check("bc_all_data", b4.out_data, 32'h5A5A5A5A);
    step();
    check("bc_drained", b4.out_valid, 0);

    // Enable gating: held beat drains while nothing new is accepted.
    b4.out_ready = 4'b0000;
    b4.in_valid = 1'b1; b4.in_sel = 2'd1; b4.in_data = 8'h77;
    step();
    check("en_held", b4.out_valid, 4'b0010);
    enable = 1'b0;
    b4.in_sel = 2'd0; b4.in_data = 8'h88;
    #1;
    check("en_off_ready", b4.in_ready, 0);
    b4.out_ready = 4'b0010;
    step();
    check("en_off_drain", b4.out_valid, 0);
    enable = 1'b1;
    #1;
    check("en_on_ready", b4.in_ready, 1);
    step();
    b4.in_valid = 1'b0;
    check("en_resume_valid", b4.out_valid, 4'b0001);
    check("en_resume_data", b4.out_data[0 +: 8], 8'h88);
    b4.out_ready = 4'hF;
    step();

    // Invalid select on the 3-channel build: sunk, error pulse, counter.
    b3.out_ready = 3'b111;
    b3.in_valid = 1'b1; b3.in_sel = 2'd3; b3.in_data = 8'hFF;
    #1;
    check("inv_ready", b3.in_ready, 1);
    check("inv_err_before", err3, 0);
    step();
    b3.in_valid = 1'b0;
    check("inv_no_out_valid", b3.out_valid, 0);
    check("inv_err_pulse", err3, 1);
    check("inv_drop_one", drop3, 1);
    step();
    check("inv_err_cleared", err3, 0);
    check("inv_drop_hold", drop3, 1);
    b3.in_valid = 1'b1;
    for (int k = 0; k < 299; k++) step();
    b3.in_valid = 1'b0;
    step();
    check("inv_drop_sat", drop3, 255);
    check("inv_u4_drop_zero", drop4, 0);

    // Async reset mid-operation with full slots and an error pulse in flight.
    b4.out_ready = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      b4.in_valid = 1'b1; b4.in_sel = 2'(s); b4.in_data = 8'hC0 + 8'(s);
      b3.in_valid = (s == 3);
      step();
    end
    b4.in_valid = 1'b0;
    b3.in_valid = 1'b0;
    check("ar_pre_full", b4.out_valid, 4'hF);
    check("ar_pre_err", err3, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", b4.out_valid, 0);
    check("ar_err_sel", err3, 0);
    check("ar_drop_count", drop3, 0);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
